// File: rtl/fifo_rd_packer.sv
// Read-side drain for a synchronous FIFO: pulls words with one-cycle read latency,
// packs PACK_RATIO of them (first word in lane 0) and presents them on valid/ready.
module fifo_rd_packer #(
    parameter int FIFO_WIDTH = 16,
    parameter int PACK_RATIO = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty,
    input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
    input  logic                             fifo_underflow,
    output logic                             fifo_rd_en,
    input  logic                             flush,
    input  logic                             pkt_ready,
    output logic                             pkt_valid,
    output logic [FIFO_WIDTH*PACK_RATIO-1:0] pkt_data,
    output logic [PACK_RATIO-1:0]            pkt_keep,
    output logic                             rd_err
);

    localparam int CW = $clog2(PACK_RATIO + 1);
    localparam int BW = FIFO_WIDTH * PACK_RATIO;
    localparam logic [CW-1:0] FULL_CNT = CW'(PACK_RATIO);

    logic [CW-1:0]         lane_cnt_reg;
    logic [CW-1:0]         lane_cnt_next;
    logic                  pending_reg;
    logic                  flush_req_reg;
    logic                  flush_req_next;
    logic                  pkt_valid_reg;
    logic [BW-1:0]         pkt_data_reg;
    logic [PACK_RATIO-1:0] pkt_keep_reg;
    logic                  rd_err_reg;
    logic [FIFO_WIDTH-1:0] lane_reg [PACK_RATIO];

    logic                  cap;
    logic [CW-1:0]         cnt_after;
    logic                  out_free;
    logic                  load_full;
    logic                  load_part;
    logic                  flush_idle;
    logic                  load_beat;
    logic [BW-1:0]         beat_data;
    logic [PACK_RATIO-1:0] beat_keep;

    // A word is owed for every outstanding read, so pending counts against lane space.
    assign fifo_rd_en = rst_n && !fifo_empty && !flush_req_reg &&
                        (({1'b0, lane_cnt_reg} + (CW+1)'(pending_reg)) < (CW+1)'(PACK_RATIO));

    assign cap        = pending_reg && !fifo_underflow;
    assign cnt_after  = lane_cnt_reg + CW'(cap);
    assign out_free   = !pkt_valid_reg || pkt_ready;
    assign load_full  = (cnt_after == FULL_CNT) && out_free;
    assign load_part  = flush_req_reg && !pending_reg && (lane_cnt_reg != '0) &&
                        (lane_cnt_reg < FULL_CNT) && out_free;
    assign flush_idle = flush_req_reg && !pending_reg && (lane_cnt_reg == '0);
    assign load_beat  = load_full || load_part;

    // The word arriving this cycle bypasses straight into its lane of the outgoing beat.
    generate
        for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
            assign beat_keep[gi] = (CW'(gi) < cnt_after);
            assign beat_data[gi*FIFO_WIDTH +: FIFO_WIDTH] =
                !beat_keep[gi] ? '0 :
                (cap && (lane_cnt_reg == CW'(gi))) ? fifo_data_out : lane_reg[gi];
        end
    endgenerate

    always_comb begin
        lane_cnt_next  = cnt_after;
        flush_req_next = flush_req_reg || flush;
        if (load_beat) begin
            lane_cnt_next = '0;
        end
        // A flush that coincides with a completing beat has nothing left to act on.
        if (load_beat || flush_idle) begin
            flush_req_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                lane_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (cap && (lane_cnt_reg == CW'(i))) begin
                    lane_reg[i] <= fifo_data_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_reg  <= '0;
            pending_reg   <= 1'b0;
            flush_req_reg <= 1'b0;
            pkt_valid_reg <= 1'b0;
            pkt_data_reg  <= '0;
            pkt_keep_reg  <= '0;
            rd_err_reg    <= 1'b0;
        end else begin
            lane_cnt_reg  <= lane_cnt_next;
            pending_reg   <= fifo_rd_en;
            flush_req_reg <= flush_req_next;
            if (fifo_underflow) begin
                rd_err_reg <= 1'b1;
            end
            if (load_beat) begin
                pkt_valid_reg <= 1'b1;
                pkt_data_reg  <= beat_data;
                pkt_keep_reg  <= beat_keep;
            end else if (pkt_ready) begin
                pkt_valid_reg <= 1'b0;
            end
        end
    end

    assign pkt_valid = pkt_valid_reg;
    assign pkt_data  = pkt_data_reg;
    assign pkt_keep  = pkt_keep_reg;
    assign rd_err    = rd_err_reg;

endmodule
